even_seq_checker: RTL

EVEN_SEQ_CHECKER -- requirements
Module: even_seq_checker

---
 rtl/even_seq_checker.sv | 107 ++++++++++
 1 files changed

// File: rtl/even_seq_checker.sv
// Lock-and-track checker for an even-step counter stream (0,2,4,6,0,...).
// Reports single-cycle errors on loss of lock and counts errors and 6->0 wraps.
module even_seq_checker #(
   parameter int unsigned LOCK_CNT = 3,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [2:0]       in_data,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] wrap_cnt,
   output logic [2:0]       expected
);

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

   localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

   state_t     state;
   logic [2:0] prev;
   logic [2:0] good;
   logic [2:0] nxt_prev;
   logic [2:0] nxt_data;
   logic [3:0] good_inc;

   function automatic logic [2:0] succ(input logic [2:0] x);
      return (x >= 3'd6) ? 3'd0 : x + 3'd2;
   endfunction

   always_comb begin
      nxt_prev = succ(prev);
      nxt_data = succ(in_data);
      good_inc = {1'b0, good} + 4'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= HUNT;
         prev     <= '0;
         good     <= '0;
         locked   <= 1'b0;
         err      <= 1'b0;
         err_cnt  <= '0;
         wrap_cnt <= '0;
         expected <= '0;
      end else begin
         err <= 1'b0;
         if (in_valid) begin
            case (state)
               HUNT: begin
                  if (!in_data[0]) begin
                     state    <= SYNC;
                     prev     <= in_data;
                     good     <= '0;
                     expected <= nxt_data;
                  end
               end
               SYNC: begin
                  if (in_data == nxt_prev) begin
                     prev     <= in_data;
                     good     <= good_inc[2:0];
                     expected <= nxt_data;
                     if (good_inc == LOCK_TGT) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end else if (!in_data[0]) begin
                     prev     <= in_data;
                     good     <= '0;
                     expected <= nxt_data;
                  end else begin
                     state    <= HUNT;
                     good     <= '0;
                     expected <= '0;
                  end
               end
               LOCKED: begin
                  if (in_data == nxt_prev) begin
                     prev     <= in_data;
                     expected <= nxt_data;
                     if (prev == 3'd6)
                        wrap_cnt <= wrap_cnt + CNT_W'(1);
                  end else begin
                     // Leaving LOCKED here is what limits errors to one per lock episode.
                     err      <= 1'b1;
                     state    <= HUNT;
                     locked   <= 1'b0;
                     good     <= '0;
                     expected <= '0;
                     if (err_cnt != '1)
                        err_cnt <= err_cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state    <= HUNT;
                  locked   <= 1'b0;
                  expected <= '0;
               end
            endcase
         end
      end
   end

endmodule
